four_bit_counter: RTL and testbench

//   Synchronous 4-bit binary counter with enable, direction, parallel load and terminal-count flag.

---
 rtl/four_bit_counter_if.sv | 11 +
 rtl/four_bit_counter.sv | 33 +++
 tb/tb_four_bit_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/four_bit_counter_if.sv
// four_bit_counter_if: control/data bundle for four_bit_counter; master drives en/up_dn/load/d, slave returns Q/tc
interface four_bit_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] Q;
  logic             tc;
  modport master (output en, up_dn, load, d, input Q, tc);
  modport slave  (input en, up_dn, load, d, output Q, tc);
endinterface

// File: rtl/four_bit_counter.sv
// four_bit_counter: up/down counter with load and terminal count; ports clk, rst (async active-low), bus (slave: en, up_dn, load, d -> Q, tc); COUNTER_SATURATE_EN selects saturation instead of wrap
module four_bit_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  four_bit_counter_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  always_comb begin
    w_at_max = r_q == {WIDTH{1'b1}};
    w_at_min = r_q == '0;
`ifdef COUNTER_SATURATE_EN
    w_up     = w_at_max ? r_q : r_q + WIDTH'(1);
    w_dn     = w_at_min ? r_q : r_q - WIDTH'(1);
`else
    w_up     = r_q + WIDTH'(1);
    w_dn     = r_q - WIDTH'(1);
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= RST_VAL;
    else if (bus.load) r_q <= bus.d;
    else if (bus.en) r_q <= bus.up_dn ? w_up : w_dn;
  assign bus.Q  = r_q;
  // gated by rst so tc stays low while held in reset even if RST_VAL sits at a limit
  assign bus.tc = rst & bus.en & (bus.up_dn ? w_at_max : w_at_min);
endmodule

// File: tb/tb_four_bit_counter.sv
// tb_four_bit_counter: randomized and directed checks of four_bit_counter against an arithmetic model
module tb_four_bit_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_q = 0;
  always #5 clk = ~clk;
  four_bit_counter_if #(.WIDTH(4)) bus ();
  four_bit_counter #(.WIDTH(4), .RST_VAL(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int exp_tc();
    return (rst && bus.en && ((bus.up_dn && m_q == 15) || (!bus.up_dn && m_q == 0))) ? 1 : 0;
  endfunction
  task automatic drive(input bit l, input bit e, input bit u, input int dv);
    @(negedge clk);
    bus.load  = l;
    bus.en    = e;
    bus.up_dn = u;
    bus.d     = 4'(dv);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) m_q = 0;
    else if (bus.load) m_q = int'(bus.d);
    else if (bus.en) begin
`ifdef COUNTER_SATURATE_EN
      if (bus.up_dn) m_q = (m_q == 15) ? 15 : m_q + 1;
      else m_q = (m_q == 0) ? 0 : m_q - 1;
`else
      m_q = bus.up_dn ? (m_q + 1) % 16 : (m_q + 15) % 16;
`endif
    end
    #1;
    check({tag, "_q"}, 8'(bus.Q), 8'(m_q));
    check({tag, "_tc"}, 8'(bus.tc), 8'(exp_tc()));
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    m_q = 0;
    check({tag, "_rst_q"}, 8'(bus.Q), 8'd0);
    check({tag, "_rst_tc"}, 8'(bus.tc), 8'd0);
    #1 rst = 1'b1;
  endtask
  initial begin
    bus.load  = 1'b0;
    bus.en    = 1'b1;
    bus.up_dn = 1'b0;
    bus.d     = 4'd0;
    #20;
    check("reset_q", 8'(bus.Q), 8'd0);
    check("reset_tc", 8'(bus.tc), 8'd0);
    @(negedge clk);
    rst       = 1'b1;
    bus.up_dn = 1'b1;
    for (int i = 0; i < 3; i++) step("release");
    drive(1, 0, 1, 0);
    step("load0");
    drive(0, 1, 1, 0);
    for (int i = 0; i < 15; i++) step("freerun");
    check("top_tc", 8'(bus.tc), 8'd1);
    step("wrap_up");
    drive(1, 0, 1, 0);
    step("load0b");
    drive(0, 1, 0, 0);
    #1 check("bottom_tc", 8'(bus.tc), 8'd1);
    step("wrap_dn");
    drive(1, 1, 1, 9);
    step("load_wins");
    check("load9", 8'(bus.Q), 8'd9);
    drive(0, 0, 1, 3);
    for (int i = 0; i < 3; i++) step("hold");
    drive(1, 0, 1, 7);
    step("load7");
    drive(0, 1, 1, 0);
    async_reset("mid");
    step("post_rst");
    check("post_rst_one", 8'(bus.Q), 8'd1);
    drive(1, 0, 1, 5);
    step("load5");
    drive(0, 1, 1, 0);
    step("dir_up");
    step("dir_up");
    drive(0, 1, 0, 0);
    step("dir_dn");
    step("dir_dn");
    check("dir_end", 8'(bus.Q), 8'd5);
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(1), $urandom_range(1), int'($urandom_range(15)));
      if ($urandom_range(24) == 0) async_reset("rnd");
      step("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
